// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between a binary source and the iterative BCD converter.
// The driver uses the master modport; the converter uses the slave modport.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  enable;
    logic                  blank_lz;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, bin_in, enable, blank_lz,
        input  busy, done, valid, overflow, bcd_out
    );

    modport slave (
        input  start, bin_in, enable, blank_lz,
        output busy, done, valid, overflow, bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with a start/done handshake,
// a sticky overflow flag and registered digits that are masked for display.
module bin_to_bcd_seq #(
    parameter int         BIN_W      = 16,
    parameter int         DIGITS     = 5,
    parameter logic [3:0] NULL_VALUE = 4'b1111
) (
    input logic             clk,
    input logic             rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * DIGITS;

    generate
        if (NULL_VALUE < 4'd10) begin : g_bad_null
            $error("bin_to_bcd_seq: NULL_VALUE must be a non-decimal code (>= 10)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   opnd_q, opnd_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   adj;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   display;
    logic               seen_nz;

    // Pre-shift correction so that each digit carries into its neighbour at ten.
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opnd_d    = bus.bin_in;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A bit leaving the top digit is a carry of 10^DIGITS: drop it, remember it.
                {scratch_d, opnd_d} = {adj[SCR_W-2:0], opnd_q, 1'b0};
                ovf_d = ovf_q | adj[SCR_W-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d   = scratch_q;
                overflow_d = ovf_q;
                valid_d    = 1'b1;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opnd_q     <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // Walk from the top digit down; digits are blank until the first non-zero one.
    always_comb begin
        display = '0;
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen_nz = seen_nz | (result_q[4*k +: 4] != 4'd0);
            if (!bus.enable || !valid_q) begin
                display[4*k +: 4] = NULL_VALUE;
            end else if (bus.blank_lz && !seen_nz && (k != 0)) begin
                display[4*k +: 4] = NULL_VALUE;
            end else begin
                display[4*k +: 4] = result_q[4*k +: 4];
            end
        end
    end

    assign bus.busy     = (state_q == S_SHIFT);
    assign bus.done     = done_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd_out  = display;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three instances (16b/5d, 16b/4d, 8b/3d)
// checked against constant vectors and a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) busA ();
    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) busB ();
    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) busC ();

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .NULL_VALUE(4'hF)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .NULL_VALUE(4'hF)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3), .NULL_VALUE(4'hF)) dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

    typedef struct {
        int              w;
        longint unsigned value;
        bit              en;
        bit              blz;
        longint unsigned expBcd;
        bit              expOvf;
    } vec_t;

    function automatic int binW(input int w);
        return (w == 2) ? 8 : 16;
    endfunction

    function automatic int digits(input int w);
        case (w)
            0:       return 5;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Displayed digits computed from the decimal value and the masking rules.
    function automatic longint unsigned expDisplay(input longint unsigned value, input int nd,
                                                   input bit en, input bit vld, input bit blz);
        longint unsigned m = value % pow10(nd);
        longint unsigned r = 0;
        int msd = 0;
        int d;
        for (int k = 0; k < nd; k++) begin
            if (((m / pow10(k)) % 10) != 0) msd = k;
        end
        for (int k = 0; k < nd; k++) begin
            d = int'((m / pow10(k)) % 10);
            if (!en || !vld) d = 15;
            else if (blz && k > msd) d = 15;
            r = r | (longint'(d) << (4 * k));
        end
        return r;
    endfunction

    function automatic logic getBusy(input int w);
        case (w)
            0:       return busA.busy;
            1:       return busB.busy;
            default: return busC.busy;
        endcase
    endfunction

    function automatic logic getDone(input int w);
        case (w)
            0:       return busA.done;
            1:       return busB.done;
            default: return busC.done;
        endcase
    endfunction

    function automatic logic getValid(input int w);
        case (w)
            0:       return busA.valid;
            1:       return busB.valid;
            default: return busC.valid;
        endcase
    endfunction

    function automatic logic getOvf(input int w);
        case (w)
            0:       return busA.overflow;
            1:       return busB.overflow;
            default: return busC.overflow;
        endcase
    endfunction

    function automatic longint unsigned getBcd(input int w);
        case (w)
            0:       return 64'(busA.bcd_out);
            1:       return 64'(busB.bcd_out);
            default: return 64'(busC.bcd_out);
        endcase
    endfunction

    task automatic applyStimulus(input int w, input logic s, input longint unsigned v,
                                 input logic en, input logic blz);
        case (w)
            0: begin
                busA.start = s; busA.bin_in = 16'(v); busA.enable = en; busA.blank_lz = blz;
            end
            1: begin
                busB.start = s; busB.bin_in = 16'(v); busB.enable = en; busB.blank_lz = blz;
            end
            default: begin
                busC.start = s; busC.bin_in = 8'(v); busC.enable = en; busC.blank_lz = blz;
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full conversion on an idle instance; bin_in is scrambled after acceptance.
    task automatic runConversion(input int w, input longint unsigned v, input bit en,
                                 input bit blz, input string name);
        int cyc;
        int busyCnt;
        @(negedge clk);
        applyStimulus(w, 1'b1, v, en, blz);
        @(posedge clk); #1;
        applyStimulus(w, 1'b0, longint'($urandom), en, blz);
        cyc = 0;
        busyCnt = 0;
        while (!getDone(w) && cyc < 60) begin
            if (getBusy(w)) busyCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({name, " latency"}, longint'(cyc), longint'(binW(w) + 1));
        checkOutput({name, " busy cycles"}, longint'(busyCnt), longint'(binW(w)));
        checkOutput({name, " digits"}, getBcd(w), expDisplay(v, digits(w), en, 1'b1, blz));
        checkOutput({name, " overflow"}, longint'(getOvf(w)), longint'(v >= pow10(digits(w))));
        checkOutput({name, " valid"}, longint'(getValid(w)), 1);
        @(posedge clk); #1;
        checkOutput({name, " done pulse width"}, longint'(getDone(w)), 0);
    endtask

    initial begin
        vec_t vecs[$];
        int   cyc;
        bit   doneSeen;
        longint unsigned v;
        bit   en, blz;

        vecs.push_back('{0, 12345, 1'b1, 1'b0, 64'h12345, 1'b0});
        vecs.push_back('{0, 65535, 1'b1, 1'b0, 64'h65535, 1'b0});
        vecs.push_back('{0, 0,     1'b1, 1'b0, 64'h00000, 1'b0});
        vecs.push_back('{0, 42,    1'b1, 1'b1, 64'hFFF42, 1'b0});
        vecs.push_back('{0, 0,     1'b1, 1'b1, 64'hFFFF0, 1'b0});
        vecs.push_back('{0, 100,   1'b1, 1'b1, 64'hFF100, 1'b0});
        vecs.push_back('{0, 10000, 1'b1, 1'b1, 64'h10000, 1'b0});
        vecs.push_back('{0, 9,     1'b0, 1'b0, 64'hFFFFF, 1'b0});
        vecs.push_back('{1, 12345, 1'b1, 1'b0, 64'h2345,  1'b1});
        vecs.push_back('{1, 9999,  1'b1, 1'b0, 64'h9999,  1'b0});
        vecs.push_back('{1, 10000, 1'b1, 1'b0, 64'h0000,  1'b1});
        vecs.push_back('{1, 10000, 1'b1, 1'b1, 64'hFFF0,  1'b1});
        vecs.push_back('{2, 255,   1'b1, 1'b0, 64'h255,   1'b0});

        for (int w = 0; w < 3; w++) applyStimulus(w, 1'b0, 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", longint'(busA.busy), 0);
        checkOutput("reset done", longint'(busA.done), 0);
        checkOutput("reset valid", longint'(busA.valid), 0);
        checkOutput("reset overflow", longint'(busA.overflow), 0);
        checkOutput("reset digits blank", 64'(busA.bcd_out), 64'hFFFFF);
        checkOutput("reset valid B", longint'(busB.valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            runConversion(vecs[i].w, vecs[i].value, vecs[i].en, vecs[i].blz, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d const digits", i), getBcd(vecs[i].w), vecs[i].expBcd);
            checkOutput($sformatf("vec%0d const ovf", i), longint'(getOvf(vecs[i].w)), longint'(vecs[i].expOvf));
        end

        // Back-to-back with start held: the second operand waits out busy and DONE.
        @(negedge clk);
        applyStimulus(0, 1'b1, 65535, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 0, 1'b1, 1'b0);
        cyc = 0;
        while (!busA.done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("b2b first latency", longint'(cyc), 17);
        checkOutput("b2b first digits", 64'(busA.bcd_out), 64'h65535);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!busA.done && cyc < 60);
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("b2b done spacing", longint'(cyc), 18);
        checkOutput("b2b second digits", 64'(busA.bcd_out), 64'h00000);
        checkOutput("b2b second ovf", longint'(busA.overflow), 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("b2b idle after drop", longint'(busA.busy), 0);

        runConversion(0, 12345, 1'b1, 1'b0, "mask base");
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        #1;
        checkOutput("enable=0 digits", 64'(busA.bcd_out), 64'hFFFFF);
        checkOutput("enable=0 valid", longint'(busA.valid), 1);
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b0);
        #1;
        checkOutput("enable=1 restore", 64'(busA.bcd_out), 64'h12345);
        checkOutput("enable=1 no done", longint'(busA.done), 0);

        // Reset sampled at the edge closing the 8th SHIFT cycle.
        @(negedge clk);
        applyStimulus(0, 1'b1, 12345, 1'b1, 1'b1);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 0, 1'b1, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("abort busy", longint'(busA.busy), 0);
        checkOutput("abort valid", longint'(busA.valid), 0);
        checkOutput("abort overflow", longint'(busA.overflow), 0);
        checkOutput("abort digits", 64'(busA.bcd_out), 64'hFFFFF);
        doneSeen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (busA.done) doneSeen = 1'b1;
        end
        checkOutput("abort no done", longint'(doneSeen), 0);
        runConversion(0, 7, 1'b1, 1'b1, "post-abort");
        checkOutput("post-abort const", 64'(busA.bcd_out), 64'hFFFF7);

        for (int i = 0; i < 30; i++) begin
            v = longint'($urandom_range(0, 65535));
            en = ($urandom_range(0, 7) != 0);
            blz = 1'($urandom_range(0, 1));
            runConversion(i % 2, v, en, blz, $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 256; i++) begin
            runConversion(2, longint'(i), 1'b1, 1'b0, $sformatf("sweep%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
